// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, fetches one 32-bit word per instruction over
// a req/ack handshake and computes the next PC from the decoder's branch outputs.
module instr_fetch #(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instruction,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_done,
    input  logic              UncondBr,
    input  logic              BrTaken,
    input  logic [18:0]       CondAddr19,
    input  logic [25:0]       BrAddr26
);

    typedef enum logic {FETCH, VALID} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] next_pc;

    // Offsets are only looked at when the branch is taken, so undriven offsets on
    // sequential paths never reach the PC.
    function automatic logic [ADDR_W-1:0] calc_next_pc(
        input logic [ADDR_W-1:0] cur_pc,
        input logic              br_taken,
        input logic              uncond,
        input logic [18:0]       cond19,
        input logic [25:0]       br26
    );
        logic signed [ADDR_W-1:0] off;
        logic        [ADDR_W-1:0] result;
        off    = '0;
        result = cur_pc + ADDR_W'(4);
        if (br_taken) begin
            if (uncond)
                off = {{(ADDR_W-26){br26[25]}}, br26};
            else
                off = {{(ADDR_W-19){cond19[18]}}, cond19};
            result = cur_pc + $unsigned(off <<< 2);
        end
        return result;
    endfunction

    assign next_pc     = calc_next_pc(instr_pc, BrTaken, UncondBr, CondAddr19, BrAddr26);
    assign imem_req    = (state == FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == VALID);

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:   if (imem_ack)   state_nxt = VALID;
            VALID:   if (instr_done) state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instruction <= 32'h0;
            instr_pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (state == FETCH && imem_ack) begin
                instruction <= imem_rdata;
                instr_pc    <= pc;
            end
            if (state == VALID && instr_done)
                pc <= next_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: per-scenario tasks, fetched words tracked in a scoreboard queue.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [63:0] instr_pc;
    logic        instr_done;
    logic        UncondBr;
    logic        BrTaken;
    logic [18:0] CondAddr19;
    logic [25:0] BrAddr26;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   passed = 0;

    instr_fetch #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .instr_pc    (instr_pc),
        .instr_done  (instr_done),
        .UncondBr    (UncondBr),
        .BrTaken     (BrTaken),
        .CondAddr19  (CondAddr19),
        .BrAddr26    (BrAddr26)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired: time %0t, limit 200000", $time);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Acknowledge the outstanding request with a word and record what must be held.
    task automatic ack_word(input logic [31:0] word, input logic [63:0] exp_pc);
        exp_t x;
        imem_ack   = 1'b1;
        imem_rdata = word;
        x.pc   = exp_pc;
        x.word = word;
        exp_q.push_back(x);
        step();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
    endtask

    // Retire the held instruction with an unconditional branch to a target.
    task automatic jump_to(input logic [63:0] from_pc, input logic [63:0] target);
        logic [63:0] diff;
        diff       = target - from_pc;
        instr_done = 1'b1;
        BrTaken    = 1'b1;
        UncondBr   = 1'b1;
        BrAddr26   = diff[27:2];
        step();
        instr_done = 1'b0;
        BrTaken    = 1'b0;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        instr_done = 1'b0;
        UncondBr   = 1'b0;
        BrTaken    = 1'b0;
        CondAddr19 = '0;
        BrAddr26   = '0;
        #12;
        checks++; if (imem_req !== 1'b1) $display("FAIL rst_req got %b exp 1", imem_req); else passed++;
        checks++; if (imem_addr !== 64'h0) $display("FAIL rst_addr got %h exp 0", imem_addr); else passed++;
        checks++; if (instr_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", instr_valid); else passed++;
        checks++; if (instruction !== 32'h0) $display("FAIL rst_instr got %h exp 0", instruction); else passed++;
        checks++; if (instr_pc !== 64'h0) $display("FAIL rst_pc got %h exp 0", instr_pc); else passed++;
        #9 reset_n = 1'b1;
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h0)
            $display("FAIL post_rst req/addr got %b/%h exp 1/0", imem_req, imem_addr); else passed++;
    endtask

    task automatic test_sequential();
        logic [63:0] a;
        for (int i = 0; i < 3; i++) begin
            a = 64'(4 * i);
            checks++; if (imem_req !== 1'b1 || imem_addr !== a || instr_valid !== 1'b0)
                $display("FAIL seq_fetch%0d req/addr/valid got %b/%h/%b exp 1/%h/0",
                         i, imem_req, imem_addr, instr_valid, a); else passed++;
            instr_done = 1'b1;
            ack_word(32'h8B020020, a);
            e = exp_q.pop_front();
            checks++; if (instr_valid !== 1'b1 || instruction !== e.word || instr_pc !== e.pc)
                $display("FAIL seq_valid%0d v/instr/pc got %b/%h/%h exp 1/%h/%h",
                         i, instr_valid, instruction, instr_pc, e.word, e.pc); else passed++;
            step();
        end
        instr_done = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 64'hC || instr_valid !== 1'b0)
            $display("FAIL seq_next req/addr/valid got %b/%h/%b exp 1/c/0",
                     imem_req, imem_addr, instr_valid); else passed++;
    endtask

    task automatic test_delayed_ack();
        for (int k = 0; k < 3; k++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 64'hC || instr_valid !== 1'b0)
                $display("FAIL wait%0d req/addr/valid got %b/%h/%b exp 1/c/0",
                         k, imem_req, imem_addr, instr_valid); else passed++;
            step();
        end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 64'hC)
            $display("FAIL wait3 req/addr got %b/%h exp 1/c", imem_req, imem_addr); else passed++;
        ack_word(32'hD2800141, 64'hC);
        e = exp_q.pop_front();
        checks++; if (instr_valid !== 1'b1 || instruction !== e.word || instr_pc !== e.pc)
            $display("FAIL delayed_valid v/instr/pc got %b/%h/%h exp 1/%h/%h",
                     instr_valid, instruction, instr_pc, e.word, e.pc); else passed++;
        jump_to(64'hC, 64'h40);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h40)
            $display("FAIL jump40 req/addr got %b/%h exp 1/40", imem_req, imem_addr); else passed++;
    endtask

    task automatic test_hold_branch();
        ack_word(32'h17FFFFFE, 64'h40);
        e = exp_q.pop_front();
        checks++; if (instr_valid !== 1'b1 || instruction !== e.word || instr_pc !== e.pc)
            $display("FAIL hold_valid v/instr/pc got %b/%h/%h exp 1/%h/%h",
                     instr_valid, instruction, instr_pc, e.word, e.pc); else passed++;
        BrTaken  = 1'b1;
        UncondBr = 1'b1;
        for (int k = 0; k < 5; k++) begin
            imem_ack   = k[0];
            imem_rdata = 32'hDEAD0000 | 32'(k);
            step();
            checks++; if (instruction !== 32'h17FFFFFE || instr_pc !== 64'h40 ||
                          imem_req !== 1'b0 || instr_valid !== 1'b1)
                $display("FAIL hold%0d instr/pc/req/v got %h/%h/%b/%b exp 17fffffe/40/0/1",
                         k, instruction, instr_pc, imem_req, instr_valid); else passed++;
        end
        imem_ack   = 1'b0;
        instr_done = 1'b1;
        BrAddr26   = 26'h3FFFFFE;
        CondAddr19 = 'x;
        step();
        instr_done = 1'b0;
        BrTaken    = 1'b0;
        CondAddr19 = '0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h38)
            $display("FAIL back_branch req/addr got %b/%h exp 1/38", imem_req, imem_addr); else passed++;
    endtask

    task automatic test_cond_branch();
        ack_word(32'h14000032, 64'h38);
        e = exp_q.pop_front();
        checks++; if (instr_pc !== e.pc || instruction !== e.word)
            $display("FAIL c38 instr/pc got %h/%h exp %h/%h", instruction, instr_pc, e.word, e.pc); else passed++;
        jump_to(64'h38, 64'h100);
        checks++; if (imem_addr !== 64'h100)
            $display("FAIL jump100 addr got %h exp 100", imem_addr); else passed++;
        ack_word(32'hB4000005, 64'h100);
        e = exp_q.pop_front();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== e.pc || instruction !== e.word)
            $display("FAIL c100 v/instr/pc got %b/%h/%h exp 1/%h/%h",
                     instr_valid, instruction, instr_pc, e.word, e.pc); else passed++;
        instr_done = 1'b1;
        BrTaken    = 1'b1;
        UncondBr   = 1'b0;
        CondAddr19 = 19'h00005;
        BrAddr26   = 'x;
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h114)
            $display("FAIL cond_fwd req/addr got %b/%h exp 1/114", imem_req, imem_addr); else passed++;
        ack_word(32'hB4FFFFFB, 64'h114);
        e = exp_q.pop_front();
        checks++; if (instr_pc !== e.pc || instruction !== e.word)
            $display("FAIL c114 instr/pc got %h/%h exp %h/%h", instruction, instr_pc, e.word, e.pc); else passed++;
        CondAddr19 = 19'h7FFFB;
        step();
        checks++; if (imem_addr !== 64'h100)
            $display("FAIL cond_back addr got %h exp 100", imem_addr); else passed++;
        ack_word(32'h91000400, 64'h100);
        e = exp_q.pop_front();
        checks++; if (instr_pc !== e.pc || instruction !== e.word)
            $display("FAIL c100b instr/pc got %h/%h exp %h/%h", instruction, instr_pc, e.word, e.pc); else passed++;
        BrTaken    = 1'b0;
        UncondBr   = 'x;
        CondAddr19 = 'x;
        step();
        instr_done = 1'b0;
        UncondBr   = 1'b0;
        CondAddr19 = '0;
        BrAddr26   = '0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h104)
            $display("FAIL not_taken_x req/addr got %b/%h exp 1/104", imem_req, imem_addr); else passed++;
    endtask

    task automatic test_wrap();
        ack_word(32'h17FFFFBE, 64'h104);
        e = exp_q.pop_front();
        checks++; if (instr_pc !== e.pc || instruction !== e.word)
            $display("FAIL w104 instr/pc got %h/%h exp %h/%h", instruction, instr_pc, e.word, e.pc); else passed++;
        jump_to(64'h104, 64'hFFFF_FFFF_FFFF_FFFC);
        checks++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC)
            $display("FAIL jump_top addr got %h exp fffffffffffffffc", imem_addr); else passed++;
        ack_word(32'hAA0003E0, 64'hFFFF_FFFF_FFFF_FFFC);
        e = exp_q.pop_front();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== e.pc || instruction !== e.word)
            $display("FAIL wtop v/instr/pc got %b/%h/%h exp 1/%h/%h",
                     instr_valid, instruction, instr_pc, e.word, e.pc); else passed++;
        instr_done = 1'b1;
        BrTaken    = 1'b0;
        step();
        instr_done = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h0)
            $display("FAIL wrap req/addr got %b/%h exp 1/0", imem_req, imem_addr); else passed++;
    endtask

    task automatic test_reset_mid_valid();
        ack_word(32'h14000008, 64'h0);
        e = exp_q.pop_front();
        checks++; if (instr_pc !== e.pc || instruction !== e.word)
            $display("FAIL r0 instr/pc got %h/%h exp %h/%h", instruction, instr_pc, e.word, e.pc); else passed++;
        jump_to(64'h0, 64'h20);
        ack_word(32'hCB030041, 64'h20);
        e = exp_q.pop_front();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== e.pc || instruction !== e.word)
            $display("FAIL r20 v/instr/pc got %b/%h/%h exp 1/%h/%h",
                     instr_valid, instruction, instr_pc, e.word, e.pc); else passed++;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h0 ||
                      instruction !== 32'h0 || instr_pc !== 64'h0)
            $display("FAIL mid_rst v/req/addr/instr/pc got %b/%b/%h/%h/%h exp 0/1/0/0/0",
                     instr_valid, imem_req, imem_addr, instruction, instr_pc); else passed++;
        step();
        reset_n = 1'b1;
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h0 || instr_valid !== 1'b0)
            $display("FAIL rel_rst req/addr/v got %b/%h/%b exp 1/0/0",
                     imem_req, imem_addr, instr_valid); else passed++;
        ack_word(32'h8B1F03E0, 64'h0);
        e = exp_q.pop_front();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== e.pc || instruction !== e.word)
            $display("FAIL late_ack v/instr/pc got %b/%h/%h exp 1/%h/%h",
                     instr_valid, instruction, instr_pc, e.word, e.pc); else passed++;
        checks++; if (exp_q.size() != 0)
            $display("FAIL sb_empty got %0d exp 0", exp_q.size()); else passed++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_delayed_ack();
        test_hold_branch();
        test_cond_branch();
        test_wrap();
        test_reset_mid_valid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
